// File: rtl/udp_ip_header_gen_pkg.sv
// Shared constants and types for the UDP/IPv4 header generator.
package udp_ip_header_gen_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
    localparam int          ETH_HDR_W      = 112;
    localparam int          IP_HDR_W       = 160;
    localparam int          UDP_HDR_W      = 64;
    localparam logic [15:0] HDR_OVERHEAD   = 16'd28;
    localparam logic [15:0] UDP_HDR_BYTES  = 16'd8;

    // Index of the last header word fed into the checksum accumulator
    localparam logic [3:0]  SUM_LAST_WORD  = 4'd8;

    // Bit positions of the four output channels in valid/acked vectors
    localparam int CH_ETH = 0;
    localparam int CH_IP  = 1;
    localparam int CH_UDP = 2;
    localparam int CH_LEN = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUM,
        ST_FOLD,
        ST_OUT
    } state_t;

endpackage

// File: rtl/udp_ip_header_gen_csum_accum.sv
// IPv4 header checksum accumulator: sums 16-bit words into a 20-bit
// register and presents the folded, complemented checksum.
module ipv4_csum_accum
    import udp_ip_header_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        add,
    input  logic        fold,
    input  logic [15:0] word,
    output logic [15:0] csum
);

    logic [19:0] acc_q;
    logic [19:0] acc_d;
    logic [16:0] s1;
    logic [16:0] s2;

    // End-around-carry fold of the accumulator into the final checksum
    always_comb begin
        s1   = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
        s2   = {1'b0, s1[15:0]} + {16'd0, s1[16]};
        csum = ~s2[15:0];
    end

    // Accumulate on add; the fold cycle consumes the sum and leaves it clear
    always_comb begin
        acc_d = acc_q;
        if (clear || fold) begin
            acc_d = '0;
        end else if (add) begin
            acc_d = acc_q + {4'd0, word};
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/udp_ip_header_gen.sv
// Builds Ethernet/IPv4/UDP headers for one request at a time and presents
// them on four independently acknowledged valid/ready channels.
module udp_ip_header_gen
    import udp_ip_header_gen_pkg::*;
#(
    parameter logic [7:0]  TTL         = 8'd64,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1472,
    parameter logic [15:0] ID_INIT     = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [47:0]          req_dst_mac,
    input  logic [47:0]          req_src_mac,
    input  logic [31:0]          req_src_ip,
    input  logic [31:0]          req_dst_ip,
    input  logic [15:0]          req_src_port,
    input  logic [15:0]          req_dst_port,
    input  logic [15:0]          req_payload_len,
    output logic [ETH_HDR_W-1:0] eth_header,
    output logic                 eth_header_valid,
    input  logic                 eth_header_ready,
    output logic [IP_HDR_W-1:0]  ip_header,
    output logic                 ip_header_valid,
    input  logic                 ip_header_ready,
    output logic [UDP_HDR_W-1:0] udp_header,
    output logic                 udp_header_valid,
    input  logic                 udp_header_ready,
    output logic [15:0]          payload_length_bytes,
    output logic                 length_valid,
    input  logic                 length_ready,
    output logic                 err_oversize
);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [3:0]             acked_q, acked_d;
    logic [3:0]             valid_q, valid_d;
    logic [15:0]            id_q, id_d;
    logic                   req_ready_q, req_ready_d;
    logic                   err_q, err_d;
    logic [47:0]            dst_mac_q, dst_mac_d;
    logic [47:0]            src_mac_q, src_mac_d;
    logic [31:0]            src_ip_q, src_ip_d;
    logic [31:0]            dst_ip_q, dst_ip_d;
    logic [15:0]            src_port_q, src_port_d;
    logic [15:0]            dst_port_q, dst_port_d;
    logic [15:0]            len_q, len_d;
    logic [ETH_HDR_W-1:0]   eth_q, eth_d;
    logic [IP_HDR_W-1:0]    ip_q, ip_d;
    logic [UDP_HDR_W-1:0]   udp_q, udp_d;
    logic [15:0]            plen_q, plen_d;

    logic                   accept;
    logic [3:0]             hs;
    logic [15:0]            tot_len;
    logic [15:0]            udp_len;
    logic [15:0]            sum_word;
    logic                   csum_clear;
    logic                   csum_add;
    logic                   csum_fold;
    logic [15:0]            csum;

    ipv4_csum_accum u_csum (
        .clk   (clk),
        .rstn  (rstn),
        .clear (csum_clear),
        .add   (csum_add),
        .fold  (csum_fold),
        .word  (sum_word),
        .csum  (csum)
    );

    // Length fields and the header word selected by the checksum counter
    always_comb begin
        tot_len = len_q + HDR_OVERHEAD;
        udp_len = len_q + UDP_HDR_BYTES;
        case (cnt_q)
            4'd0:    sum_word = {IP_VER_IHL, 8'h00};
            4'd1:    sum_word = tot_len;
            4'd2:    sum_word = id_q;
            4'd3:    sum_word = IP_FLAGS_DF;
            4'd4:    sum_word = {TTL, IP_PROTO_UDP};
            4'd5:    sum_word = src_ip_q[31:16];
            4'd6:    sum_word = src_ip_q[15:0];
            4'd7:    sum_word = dst_ip_q[31:16];
            default: sum_word = dst_ip_q[15:0];
        endcase
    end

    // Next-state logic: request capture, checksum sequencing, channel acks
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acked_d    = acked_q;
        valid_d    = valid_q;
        id_d       = id_q;
        err_d      = 1'b0;
        dst_mac_d  = dst_mac_q;
        src_mac_d  = src_mac_q;
        src_ip_d   = src_ip_q;
        dst_ip_d   = dst_ip_q;
        src_port_d = src_port_q;
        dst_port_d = dst_port_q;
        len_d      = len_q;
        eth_d      = eth_q;
        ip_d       = ip_q;
        udp_d      = udp_q;
        plen_d     = plen_q;
        csum_clear = 1'b0;
        csum_add   = 1'b0;
        csum_fold  = 1'b0;
        accept     = req_valid && req_ready_q;
        hs         = valid_q & {length_ready, udp_header_ready,
                                ip_header_ready, eth_header_ready};

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dst_mac_d  = req_dst_mac;
                    src_mac_d  = req_src_mac;
                    src_ip_d   = req_src_ip;
                    dst_ip_d   = req_dst_ip;
                    src_port_d = req_src_port;
                    dst_port_d = req_dst_port;
                    len_d      = req_payload_len;
                    if (req_payload_len > MAX_PAYLOAD) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = ST_SUM;
                        cnt_d      = 4'd0;
                        csum_clear = 1'b1;
                    end
                end
            end
            ST_SUM: begin
                csum_add = 1'b1;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == SUM_LAST_WORD) begin
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: begin
                csum_fold = 1'b1;
                eth_d     = {dst_mac_q, src_mac_q, ETHERTYPE_IPV4};
                ip_d      = {IP_VER_IHL, 8'h00, tot_len, id_q, IP_FLAGS_DF,
                             TTL, IP_PROTO_UDP, csum, src_ip_q, dst_ip_q};
                udp_d     = {src_port_q, dst_port_q, udp_len, 16'h0000};
                plen_d    = len_q;
                valid_d   = 4'hF;
                acked_d   = 4'h0;
                state_d   = ST_OUT;
            end
            default: begin
                valid_d = valid_q & ~hs;
                acked_d = acked_q | hs;
                if (acked_d == 4'hF) begin
                    acked_d = 4'h0;
                    id_d    = id_q + 16'd1;
                    state_d = ST_IDLE;
                end
            end
        endcase

        req_ready_d = (state_d == ST_IDLE) && !accept;
    end

    // State and datapath registers; reset discards any packet in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acked_q     <= '0;
            valid_q     <= '0;
            id_q        <= ID_INIT;
            req_ready_q <= 1'b0;
            err_q       <= 1'b0;
            dst_mac_q   <= '0;
            src_mac_q   <= '0;
            src_ip_q    <= '0;
            dst_ip_q    <= '0;
            src_port_q  <= '0;
            dst_port_q  <= '0;
            len_q       <= '0;
            eth_q       <= '0;
            ip_q        <= '0;
            udp_q       <= '0;
            plen_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acked_q     <= acked_d;
            valid_q     <= valid_d;
            id_q        <= id_d;
            req_ready_q <= req_ready_d;
            err_q       <= err_d;
            dst_mac_q   <= dst_mac_d;
            src_mac_q   <= src_mac_d;
            src_ip_q    <= src_ip_d;
            dst_ip_q    <= dst_ip_d;
            src_port_q  <= src_port_d;
            dst_port_q  <= dst_port_d;
            len_q       <= len_d;
            eth_q       <= eth_d;
            ip_q        <= ip_d;
            udp_q       <= udp_d;
            plen_q      <= plen_d;
        end
    end

    assign req_ready            = req_ready_q;
    assign err_oversize         = err_q;
    assign eth_header           = eth_q;
    assign ip_header            = ip_q;
    assign udp_header           = udp_q;
    assign payload_length_bytes = plen_q;
    assign eth_header_valid     = valid_q[CH_ETH];
    assign ip_header_valid      = valid_q[CH_IP];
    assign udp_header_valid     = valid_q[CH_UDP];
    assign length_valid         = valid_q[CH_LEN];

endmodule

// File: tb/tb_udp_ip_header_gen.sv
// Self-checking bench for udp_ip_header_gen: table-driven packets with a
// scoreboard of expected headers, plus hand sequences for ack ordering,
// stalls, oversize rejects, mid-packet reset and id wrap.
module tb_udp_ip_header_gen;

    typedef struct {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] len;
        logic        oversize;
        logic [15:0] exp_tot;
        logic [15:0] exp_udp;
        logic        csum_given;
        logic [15:0] exp_csum;
    } vec_t;

    typedef struct {
        logic [111:0] eth;
        logic [159:0] ip;
        logic [63:0]  udp;
        logic [15:0]  len;
    } exp_t;

    logic         clk;
    logic         rstn;
    logic         req_valid, req_valid_b;
    logic         req_ready, req_ready_b;
    logic [47:0]  req_dst_mac, req_src_mac;
    logic [31:0]  req_src_ip, req_dst_ip;
    logic [15:0]  req_src_port, req_dst_port, req_payload_len;
    logic [111:0] eth_header, eth_header_b;
    logic [159:0] ip_header, ip_header_b;
    logic [63:0]  udp_header, udp_header_b;
    logic [15:0]  payload_length_bytes, payload_length_bytes_b;
    logic         eth_header_valid, ip_header_valid, udp_header_valid, length_valid;
    logic         eth_header_valid_b, ip_header_valid_b, udp_header_valid_b, length_valid_b;
    logic [3:0]   rdy;
    logic         rdy_b;
    logic         err_oversize, err_oversize_b;
    logic [3:0]   valids, valids_b;

    int           n_checks;
    int           n_fail;
    int           cyc;
    int           accept_cyc;
    logic [15:0]  exp_id;
    exp_t         sb[$];
    vec_t         tbl[5];

    assign valids   = {length_valid, udp_header_valid, ip_header_valid, eth_header_valid};
    assign valids_b = {length_valid_b, udp_header_valid_b, ip_header_valid_b, eth_header_valid_b};

    udp_ip_header_gen dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dst_mac(req_dst_mac), .req_src_mac(req_src_mac),
        .req_src_ip(req_src_ip), .req_dst_ip(req_dst_ip),
        .req_src_port(req_src_port), .req_dst_port(req_dst_port),
        .req_payload_len(req_payload_len),
        .eth_header(eth_header), .eth_header_valid(eth_header_valid), .eth_header_ready(rdy[0]),
        .ip_header(ip_header), .ip_header_valid(ip_header_valid), .ip_header_ready(rdy[1]),
        .udp_header(udp_header), .udp_header_valid(udp_header_valid), .udp_header_ready(rdy[2]),
        .payload_length_bytes(payload_length_bytes), .length_valid(length_valid), .length_ready(rdy[3]),
        .err_oversize(err_oversize)
    );

    // Second instance starts its id counter at the wrap point
    udp_ip_header_gen #(.ID_INIT(16'hFFFF)) dut_b (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_dst_mac(req_dst_mac), .req_src_mac(req_src_mac),
        .req_src_ip(req_src_ip), .req_dst_ip(req_dst_ip),
        .req_src_port(req_src_port), .req_dst_port(req_dst_port),
        .req_payload_len(req_payload_len),
        .eth_header(eth_header_b), .eth_header_valid(eth_header_valid_b), .eth_header_ready(rdy_b),
        .ip_header(ip_header_b), .ip_header_valid(ip_header_valid_b), .ip_header_ready(rdy_b),
        .udp_header(udp_header_b), .udp_header_valid(udp_header_valid_b), .udp_header_ready(rdy_b),
        .payload_length_bytes(payload_length_bytes_b), .length_valid(length_valid_b), .length_ready(rdy_b),
        .err_oversize(err_oversize_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkEq(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference one's-complement checksum over the IPv4 header words
    function automatic logic [15:0] modelCsum(input logic [15:0] tot, input logic [15:0] id,
                                              input logic [31:0] sip, input logic [31:0] dip);
        logic [31:0] s;
        s = 32'h4500 + {16'h0, tot} + {16'h0, id} + 32'h4000 + 32'h4011
            + {16'h0, sip[31:16]} + {16'h0, sip[15:0]}
            + {16'h0, dip[31:16]} + {16'h0, dip[15:0]};
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return ~s[15:0];
    endfunction

    function automatic exp_t buildExp(input vec_t v, input logic [15:0] id);
        exp_t        e;
        logic [15:0] c;
        c     = v.csum_given ? v.exp_csum : modelCsum(v.exp_tot, id, v.src_ip, v.dst_ip);
        e.eth = {v.dst_mac, v.src_mac, 16'h0800};
        e.ip  = {8'h45, 8'h00, v.exp_tot, id, 16'h4000, 8'd64, 8'h11, c, v.src_ip, v.dst_ip};
        e.udp = {v.src_port, v.dst_port, v.exp_udp, 16'h0000};
        e.len = v.len;
        return e;
    endfunction

    // Drive one request into the main DUT and record what it should produce
    task automatic applyStimulus(input vec_t v);
        int t;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) checkEq("req_ready_wait", 160'(req_ready), 160'(1));
        req_dst_mac     = v.dst_mac;
        req_src_mac     = v.src_mac;
        req_src_ip      = v.src_ip;
        req_dst_ip      = v.dst_ip;
        req_src_port    = v.src_port;
        req_dst_port    = v.dst_port;
        req_payload_len = v.len;
        req_valid       = 1'b1;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        if (!v.oversize) begin
            sb.push_back(buildExp(v, exp_id));
            exp_id = exp_id + 16'd1;
        end
    endtask

    // Wait for the header set, check its latency and compare with the scoreboard
    task automatic checkOutput();
        int   t;
        exp_t e;
        t = 0;
        while (valids != 4'hF && t < 40) begin
            @(negedge clk);
            t++;
        end
        checkEq("valids_up", 160'(valids), 160'(4'hF));
        // Accept cycle + 9 sum cycles + 1 fold cycle: valids set by the 10th edge after accept
        checkEq("latency", 160'(cyc - accept_cyc), 160'(10));
        if (sb.size() == 0) begin
            checkEq("scoreboard_nonempty", 160'(0), 160'(1));
        end else begin
            e = sb.pop_front();
            checkEq("eth_header", 160'(eth_header), 160'(e.eth));
            checkEq("ip_header", ip_header, e.ip);
            checkEq("udp_header", 160'(udp_header), 160'(e.udp));
            checkEq("payload_len", 160'(payload_length_bytes), 160'(e.len));
        end
    endtask

    task automatic ackAll();
        rdy = 4'hF;
        @(negedge clk);
        rdy = 4'h0;
        checkEq("valids_after_ack", 160'(valids), 160'(0));
        checkEq("req_ready_after_ack", 160'(req_ready), 160'(1));
    endtask

    initial begin
        vec_t v;
        int   order[4];
        logic [3:0] remaining;
        logic stable;
        logic [159:0] cap_ip;
        logic [111:0] cap_eth;
        exp_t eb;

        n_checks = 0; n_fail = 0; cyc = 0; exp_id = 16'h0000;
        rstn = 1'b0; req_valid = 1'b0; req_valid_b = 1'b0; rdy = 4'h0; rdy_b = 1'b0;
        req_dst_mac = '0; req_src_mac = '0; req_src_ip = '0; req_dst_ip = '0;
        req_src_port = '0; req_dst_port = '0; req_payload_len = '0;

        //          dst_mac           src_mac           src_ip        dst_ip        sport    dport    len      ovr   tot      udp      cg    csum
        tbl[0] = '{48'h001122334455, 48'h66778899AABB, 32'hC0A8010A, 32'hC0A80114, 16'd1234, 16'd5678, 16'd100,  1'b0, 16'h0080, 16'h006C, 1'b1, 16'hB6FE};
        tbl[1] = '{48'h001122334455, 48'h66778899AABB, 32'hC0A8010A, 32'hC0A80114, 16'd1234, 16'd5678, 16'd0,    1'b0, 16'h001C, 16'h0008, 1'b1, 16'hB761};
        tbl[2] = '{48'hFFFFFFFFFFFF, 48'h0A0B0C0D0E0F, 32'h0A000001, 32'h0A000002, 16'd53,   16'd53,   16'd1473, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        tbl[3] = '{48'hFFFFFFFFFFFF, 48'h0A0B0C0D0E0F, 32'h0A000001, 32'h0A000002, 16'd53,   16'd53,   16'd1472, 1'b0, 16'h05DC, 16'h05C8, 1'b0, 16'h0000};
        tbl[4] = '{48'h020000000001, 48'h020000000002, 32'h0A000001, 32'hFFFFFFFF, 16'hFFFF, 16'h0001, 16'd512,  1'b0, 16'h021C, 16'h0208, 1'b0, 16'h0000};

        // Reset state
        repeat (2) @(negedge clk);
        checkEq("rst_req_ready", 160'(req_ready), 160'(0));
        checkEq("rst_valids", 160'(valids), 160'(0));
        checkEq("rst_err", 160'(err_oversize), 160'(0));
        checkEq("rst_ip_header", ip_header, 160'(0));
        rstn = 1'b1;
        #1 checkEq("req_ready_before_edge", 160'(req_ready), 160'(0));
        @(negedge clk);
        checkEq("req_ready_after_release", 160'(req_ready), 160'(1));

        // Table-driven packets
        for (int i = 0; i < 5; i++) begin
            applyStimulus(tbl[i]);
            if (tbl[i].oversize) begin
                checkEq("err_pulse", 160'(err_oversize), 160'(1));
                checkEq("err_req_ready_low", 160'(req_ready), 160'(0));
                checkEq("err_no_valids", 160'(valids), 160'(0));
                @(negedge clk);
                checkEq("err_pulse_end", 160'(err_oversize), 160'(0));
                checkEq("err_req_ready_back", 160'(req_ready), 160'(1));
                repeat (12) @(negedge clk);
                checkEq("err_still_no_valids", 160'(valids), 160'(0));
            end else begin
                checkOutput();
                ackAll();
            end
        end

        // Individually strobed acks in order udp, len, eth, ip
        v = tbl[0];
        v.csum_given = 1'b0;
        applyStimulus(v);
        checkOutput();
        order = '{2, 3, 0, 1};
        remaining = 4'hF;
        for (int k = 0; k < 4; k++) begin
            rdy = 4'(1 << order[k]);
            remaining[order[k]] = 1'b0;
            @(negedge clk);
            rdy = 4'h0;
            checkEq("strobe_valids", 160'(valids), 160'(remaining));
            checkEq("strobe_req_ready", 160'(req_ready), 160'(k == 3));
        end

        // Stall in OUT with no readies while a new request waits
        v = tbl[4];
        applyStimulus(v);
        checkOutput();
        cap_ip = ip_header;
        cap_eth = eth_header;
        req_valid = 1'b1;
        stable = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (valids != 4'hF || ip_header != cap_ip || eth_header != cap_eth || req_ready)
                stable = 1'b0;
        end
        checkEq("stall_stable", 160'(stable), 160'(1));
        req_valid = 1'b0;
        ackAll();

        // Reset three cycles into SUM
        applyStimulus(tbl[1]);
        repeat (3) @(posedge clk);
        #2 rstn = 1'b0;
        #1 checkEq("rst_sum_valids", 160'(valids), 160'(0));
        checkEq("rst_sum_req_ready", 160'(req_ready), 160'(0));
        sb.delete();
        exp_id = 16'h0000;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Reset while headers are presented: valids must drop without a clock edge
        applyStimulus(tbl[4]);
        checkOutput();
        #2 rstn = 1'b0;
        #1 checkEq("rst_out_valids", 160'(valids), 160'(0));
        checkEq("rst_out_eth", 160'(eth_header), 160'(0));
        sb.delete();
        exp_id = 16'h0000;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Full packet after reset carries the initial id again
        applyStimulus(tbl[0]);
        checkOutput();
        ackAll();

        // Identification wrap on the second instance
        v = tbl[0];
        v.csum_given = 1'b0;
        for (int k = 0; k < 2; k++) begin
            int t;
            req_dst_mac = v.dst_mac; req_src_mac = v.src_mac;
            req_src_ip = v.src_ip; req_dst_ip = v.dst_ip;
            req_src_port = v.src_port; req_dst_port = v.dst_port;
            req_payload_len = v.len;
            t = 0;
            while (!req_ready_b && t < 50) begin
                @(negedge clk);
                t++;
            end
            req_valid_b = 1'b1;
            @(negedge clk);
            req_valid_b = 1'b0;
            t = 0;
            while (valids_b != 4'hF && t < 40) begin
                @(negedge clk);
                t++;
            end
            checkEq("wrap_valids", 160'(valids_b), 160'(4'hF));
            eb = buildExp(v, (k == 0) ? 16'hFFFF : 16'h0000);
            checkEq("wrap_ip_header", ip_header_b, eb.ip);
            rdy_b = 1'b1;
            @(negedge clk);
            rdy_b = 1'b0;
            checkEq("wrap_valids_cleared", 160'(valids_b), 160'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
